alu_exec_ctrl: RTL and testbench

//  Execute/writeback stage directly upstream of the 8-bit ALU. Accepts 8-bit instructions over valid/ready,

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_exec_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its execute/writeback controller:
// opcodes, flag bit positions, FSM encoding and the instruction word layout.
package alu_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned FLAG_W   = 2;
  localparam int unsigned INSTR_W  = 8;

  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [OP_W-1:0] OP_NOP   = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
  localparam logic [OP_W-1:0] OP_NAND  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SHL   = 4'b0100;
  localparam logic [OP_W-1:0] OP_SHR   = 4'b0101;
  localparam logic [OP_W-1:0] OP_OUT   = 4'b0110;
  localparam logic [OP_W-1:0] OP_IN    = 4'b0111;
  localparam logic [OP_W-1:0] OP_MOV   = 4'b1000;
  localparam logic [OP_W-1:0] OP_STORE = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_EXEC     = 2'b01,
    S_WAIT_OUT = 2'b10,
    S_WAIT_IN  = 2'b11
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
  } instr_t;

  // Opcodes whose ALU result is written back to R[rd] during EXEC.
  function automatic logic op_writes_alu(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR, OP_MOV: op_writes_alu = 1'b1;
      default:                                         op_writes_alu = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4-entry architectural register file: two asynchronous read ports, one
// synchronous write port, all entries cleared by reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [REG_AW-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [REG_AW-1:0]            raddr_a,
  input  logic [REG_AW-1:0]            raddr_b,
  output logic [DATA_W-1:0]            rdata_a_c,
  output logic [DATA_W-1:0]            rdata_b_c,
  output logic [NUM_REGS*DATA_W-1:0]   regs_c
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a_c = mem[raddr_a];
  assign rdata_b_c = mem[raddr_b];

  // Flattened view, R3 in the top slice.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_c[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute/writeback controller in front of the 8-bit ALU: accepts one
// instruction at a time, drives the ALU, writes back results and flags.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IN_TIMEOUT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  input  logic [INSTR_W-1:0]         instr,
  output logic                       instr_ready,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [OP_W-1:0]            alu_sel,
  input  logic [DATA_W-1:0]          alu_y,
  input  logic [FLAG_W-1:0]          alu_flag,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [REG_AW-1:0]          out_addr,
  output logic                       out_is_store,
  input  logic                       out_ready,
  output logic [FLAG_W-1:0]          flags,
  output logic                       in_timeout,
  output logic [NUM_REGS*DATA_W-1:0] dbg_regs
);

  localparam int unsigned CNT_W = (IN_TIMEOUT > 1) ? $clog2(IN_TIMEOUT) : 1;

  state_t            state;
  instr_t            instr_s;
  instr_t            instr_q;
  logic [CNT_W-1:0]  cnt;
  logic              timeout_hit;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;

  assign instr_s = instr_t'(instr);

  alu_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (instr_q.rd),
    .wdata     (rf_wdata),
    .raddr_a   (instr_q.rd),
    .raddr_b   (instr_q.rs),
    .rdata_a_c (rd_val),
    .rdata_b_c (rs_val),
    .regs_c    (dbg_regs)
  );

  // Operands are read straight from the register file using the captured fields.
  assign alu_a = rd_val;
  assign alu_b = rs_val;

  assign timeout_hit = (IN_TIMEOUT != 0) && (cnt == CNT_W'(IN_TIMEOUT - 1));

  // Writeback source select: ALU result in EXEC, input word (or zero on timeout) in WAIT_IN.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    case (state)
      S_EXEC: begin
        if (op_writes_alu(instr_q.opcode)) begin
          rf_we    = 1'b1;
          rf_wdata = alu_y;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          rf_we    = 1'b1;
          rf_wdata = in_data;
        end else if (timeout_hit) begin
          rf_we    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      instr_q      <= '0;
      cnt          <= '0;
      flags        <= '0;
      instr_ready  <= 1'b1;
      in_ready     <= 1'b0;
      alu_sel      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_addr     <= '0;
      out_is_store <= 1'b0;
      in_timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr_s;
            alu_sel     <= instr_s.opcode;
            instr_ready <= 1'b0;
            state       <= S_EXEC;
          end
        end

        S_EXEC: begin
          // Single-cycle ops return to IDLE; handshake ops override below.
          alu_sel     <= '0;
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          case (instr_q.opcode)
            OP_ADD, OP_SUB, OP_NAND: flags <= alu_flag;
            OP_SHL, OP_SHR:          flags[FLAG_Z] <= alu_flag[FLAG_Z];
            OP_OUT, OP_STORE: begin
              out_valid    <= 1'b1;
              out_data     <= rd_val;
              out_addr     <= (instr_q.opcode == OP_STORE) ? instr_q.rs : '0;
              out_is_store <= (instr_q.opcode == OP_STORE);
              instr_ready  <= 1'b0;
              state        <= S_WAIT_OUT;
            end
            OP_IN: begin
              cnt         <= '0;
              in_ready    <= 1'b1;
              instr_ready <= 1'b0;
              state       <= S_WAIT_IN;
            end
            default: ;
          endcase
        end

        S_WAIT_OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end

        S_WAIT_IN: begin
          // Data arriving on the last permitted cycle beats the timeout.
          if (in_valid || timeout_hit) begin
            in_ready    <= 1'b0;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
            if (!in_valid) begin
              in_timeout <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          in_ready    <= 1'b0;
          out_valid   <= 1'b0;
          alu_sel     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural 8-bit ALU attached.
module tb_alu_exec_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [7:0]  instr;
  logic        instr_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_y;
  logic [1:0]  alu_flag;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_addr;
  logic        out_is_store;
  logic        out_ready;
  logic [1:0]  flags;
  logic        in_timeout;
  logic [31:0] dbg_regs;

  int checks = 0;
  int errors = 0;

  alu_exec_ctrl #(
    .DATA_W     (8),
    .IN_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_y        (alu_y),
    .alu_flag     (alu_flag),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .out_is_store (out_is_store),
    .out_ready    (out_ready),
    .flags        (flags),
    .in_timeout   (in_timeout),
    .dbg_regs     (dbg_regs)
  );

  // Reference ALU: flags are {Z,N}; shifts report the shifted-out bit as Z.
  always_comb begin
    alu_y    = 8'h00;
    alu_flag = 2'b00;
    case (alu_sel)
      4'b0001: alu_y = alu_a + alu_b;
      4'b0010: alu_y = alu_a - alu_b;
      4'b0011: alu_y = ~(alu_a & alu_b);
      4'b0100: alu_y = {alu_a[6:0], 1'b0};
      4'b0101: alu_y = {1'b0, alu_a[7:1]};
      4'b1000: alu_y = alu_b;
      default: alu_y = 8'h00;
    endcase
    case (alu_sel)
      4'b0100: alu_flag = {alu_a[7], alu_y[7]};
      4'b0101: alu_flag = {alu_a[0], alu_y[7]};
      default: alu_flag = {(alu_y == 8'h00), alu_y[7]};
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction at a negedge; returns at the negedge after the accept edge (EXEC).
  task automatic issue(input logic [7:0] x);
    check("instr_ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = x;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic alu_op(input string tag, input logic [7:0] x,
                        input logic [31:0] exp_regs, input logic [1:0] exp_flags);
    issue(x);
    check({tag, "_sel"}, {28'd0, alu_sel}, {28'd0, x[7:4]});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_regs"}, dbg_regs, exp_regs);
    check({tag, "_flags"}, {30'd0, flags}, {30'd0, exp_flags});
    check({tag, "_sel_idle"}, {28'd0, alu_sel}, 32'd0);
  endtask

  task automatic in_load(input string tag, input logic [7:0] x, input logic [7:0] d);
    logic done;
    done = 1'b0;
    issue(x);
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 8 && !done; k++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, "_handshake"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 8'h00;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_regs", dbg_regs, 32'h0);
    check("rst_flags", {30'd0, flags}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_timeout", {31'd0, in_timeout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload via IN, then ALU ops.
    in_load("in_r1", 8'h75, 8'h05);
    in_load("in_r2", 8'h79, 8'h03);
    check("preload_regs", dbg_regs, 32'h00030500);
    check("preload_flags", {30'd0, flags}, 32'd0);

    issue(8'h16);
    check("add_a", {24'd0, alu_a}, 32'h05);
    check("add_b", {24'd0, alu_b}, 32'h03);
    check("add_not_yet", dbg_regs, 32'h00030500);
    @(posedge clk);
    @(negedge clk);
    check("add_regs", dbg_regs, 32'h00030800);
    check("add_flags", {30'd0, flags}, 32'd0);

    alu_op("sub_r2r2", 8'h2A, 32'h00000800, 2'b10);
    alu_op("sub_r3r1", 8'h2D, 32'hF8000800, 2'b01);
    in_load("in_r1_81", 8'h75, 8'h81);
    check("in_keeps_flags", {30'd0, flags}, 32'd1);
    alu_op("shl", 8'h44, 32'hF8000200, 2'b11);
    alu_op("shr", 8'h54, 32'hF8000100, 2'b01);
    alu_op("mov", 8'h83, 32'hF80001F8, 2'b01);
    alu_op("add_wrap", 8'h10, 32'hF80001F0, 2'b01);
    alu_op("nand", 8'h39, 32'hF8FF01F0, 2'b01);
    alu_op("nop", 8'hA5, 32'hF8FF01F0, 2'b01);

    // STORE with a stalled consumer; a stray instruction offered meanwhile is ignored.
    issue(8'h96);
    check("store_exec_ov", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("store_hold_valid", {31'd0, out_valid}, 32'd1);
      check("store_hold_data", {24'd0, out_data}, 32'h01);
      check("store_hold_addr", {30'd0, out_addr}, 32'd2);
      check("store_hold_is_store", {31'd0, out_is_store}, 32'd1);
      check("store_hold_iready", {31'd0, instr_ready}, 32'd0);
      instr_valid = (k == 0);
      instr       = 8'h10;
      @(posedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    out_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("store_done_ov", {31'd0, out_valid}, 32'd0);
    check("store_done_iready", {31'd0, instr_ready}, 32'd1);
    check("store_done_regs", dbg_regs, 32'hF8FF01F0);

    // OUT with the consumer already ready.
    issue(8'h6C);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_data", {24'd0, out_data}, 32'hF8);
    check("out_addr", {30'd0, out_addr}, 32'd0);
    check("out_is_store", {31'd0, out_is_store}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_done_ov", {31'd0, out_valid}, 32'd0);
    check("out_done_iready", {31'd0, instr_ready}, 32'd1);

    // IN R2: data arrives on the final permitted WAIT_IN cycle.
    issue(8'h78);
    @(posedge clk);
    @(negedge clk);
    check("win_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("win_still_waiting", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("win_regs", dbg_regs, 32'hF85A01F0);
    check("win_no_timeout", {31'd0, in_timeout}, 32'd0);
    check("win_iready", {31'd0, instr_ready}, 32'd1);

    // IN R3 with no data: times out after four WAIT_IN cycles.
    issue(8'h7C);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("to_pending_in_ready", {31'd0, in_ready}, 32'd1);
    check("to_pending_flag", {31'd0, in_timeout}, 32'd0);
    check("to_pending_regs", dbg_regs, 32'hF85A01F0);
    @(posedge clk);
    @(negedge clk);
    check("to_regs", dbg_regs, 32'h005A01F0);
    check("to_flag", {31'd0, in_timeout}, 32'd1);
    check("to_iready", {31'd0, instr_ready}, 32'd1);
    check("to_in_ready", {31'd0, in_ready}, 32'd0);
    check("to_flags_kept", {30'd0, flags}, 32'd1);

    // Reset while an output word is pending.
    issue(8'h91);
    @(posedge clk);
    @(negedge clk);
    check("rwo_valid", {31'd0, out_valid}, 32'd1);
    check("rwo_data", {24'd0, out_data}, 32'hF0);
    check("rwo_addr", {30'd0, out_addr}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rwo_ov_dropped", {31'd0, out_valid}, 32'd0);
    check("rwo_regs", dbg_regs, 32'h0);
    check("rwo_flags", {30'd0, flags}, 32'd0);
    check("rwo_timeout", {31'd0, in_timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rwo_iready", {31'd0, instr_ready}, 32'd1);
    check("rwo_out_valid", {31'd0, out_valid}, 32'd0);
    alu_op("post_rst_add", 8'h10, 32'h0, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
